// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped L1 data-cache controller:
// FSM state encoding and the address field widths used to split a
// 32-bit byte address into tag / index / word-select / byte-offset.
package dcache_pkg;

   localparam int LINE_BITS  = 256;
   localparam int TAG_W      = 23;
   localparam int IDX_W      = 4;
   localparam int WORD_SEL_W = 3;
   localparam int OFFSET_W   = 5;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WRITEBACK = 2'd1,
      ST_ALLOCATE  = 2'd2,
      ST_REFILL    = 2'd3
   } state_e;

endpackage

// File: rtl/dcache_sram.sv
// Cache data array: LINES x LINE_BITS, one write port and a combinational
// read port sharing a single line index.
// Ports:
//   clk_i       clock
//   we_i        write enable
//   full_i      1 = write whole line from line_i, 0 = write one word from word_i
//   idx_i       line index (read and write)
//   word_sel_i  word within the line for single-word writes
//   line_i      refill line data
//   word_i      store data
//   line_o      selected line, combinational
module dcache_sram
   import dcache_pkg::*;
#(
   parameter int LINES     = 16,
   parameter int LINE_BITS = 256
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic                  full_i,
   input  logic [IDX_W-1:0]      idx_i,
   input  logic [WORD_SEL_W-1:0] word_sel_i,
   input  logic [LINE_BITS-1:0]  line_i,
   input  logic [31:0]           word_i,
   output logic [LINE_BITS-1:0]  line_o
);

   logic [LINE_BITS-1:0] mem_q [LINES];

   // No reset: contents are only observable through a valid tag match.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         if (full_i) begin
            mem_q[idx_i] <= line_i;
         end else begin
            mem_q[idx_i][{word_sel_i, 5'b0} +: 32] <= word_i;
         end
      end
   end

   assign line_o = mem_q[idx_i];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate L1 data-cache controller.
// Holds tag/valid/dirty per line, sequences writeback and refill over a
// req/ack line-wide memory handshake and stalls the pipeline on misses.
// Ports:
//   clk_i, start_i         clock, synchronous active-low reset
//   cpu_req_i/write_i      access request, 1 = store
//   cpu_addr_i/data_i      word-aligned byte address, store data
//   cpu_data_o             load data (valid on an unstalled request)
//   cpu_stall_o            freeze the pipeline
//   mem_enable_o/write_o   memory request (held until ack), 1 = line write
//   mem_addr_o/data_o      line address, writeback line
//   mem_data_i/ack_i       refill line, single-cycle completion pulse
//
// state     | meaning
// IDLE      | serve hits; launch writeback or refill on a miss
// WRITEBACK | dirty victim line being written to memory
// ALLOCATE  | new line being read from memory
// REFILL    | line installed; one cycle before the access replays as a hit
module dcache_controller #(
   parameter int LINES     = 16,
   parameter int LINE_BITS = 256,
   parameter int ADDR_W    = 32
) (
   input  logic                 clk_i,
   input  logic                 start_i,
   input  logic                 cpu_req_i,
   input  logic                 cpu_write_i,
   input  logic [ADDR_W-1:0]    cpu_addr_i,
   input  logic [31:0]          cpu_data_i,
   output logic [31:0]          cpu_data_o,
   output logic                 cpu_stall_o,
   output logic                 mem_enable_o,
   output logic                 mem_write_o,
   output logic [ADDR_W-1:0]    mem_addr_o,
   output logic [LINE_BITS-1:0] mem_data_o,
   input  logic [LINE_BITS-1:0] mem_data_i,
   input  logic                 mem_ack_i
);

   import dcache_pkg::*;

   state_e               state_q, state_d;
   logic [LINES-1:0]     valid_q, valid_d;
   logic [LINES-1:0]     dirty_q, dirty_d;
   logic [TAG_W-1:0]     tag_q [LINES];
   logic                 tag_we;
   logic                 mem_en_q, mem_en_d;
   logic                 mem_wr_q, mem_wr_d;
   logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
   logic [LINE_BITS-1:0] mem_data_q, mem_data_d;

   logic [TAG_W-1:0]      addr_tag;
   logic [IDX_W-1:0]      idx;
   logic [WORD_SEL_W-1:0] wsel;
   logic                  hit;
   logic                  sram_we;
   logic                  sram_full;
   logic [LINE_BITS-1:0]  line_rd;
   logic                  unused_addr_bits;

   assign addr_tag = cpu_addr_i[ADDR_W-1 -: TAG_W];
   assign idx      = cpu_addr_i[OFFSET_W +: IDX_W];
   assign wsel     = cpu_addr_i[2 +: WORD_SEL_W];
   assign unused_addr_bits = ^cpu_addr_i[1:0];

   assign hit         = cpu_req_i & valid_q[idx] & (tag_q[idx] == addr_tag);
   assign cpu_stall_o = (cpu_req_i & ~hit) | (state_q != ST_IDLE);
   // Gated by hit so the data bus reads zero until the line is resident.
   assign cpu_data_o  = hit ? line_rd[{wsel, 5'b0} +: 32] : 32'h0;

   assign mem_enable_o = mem_en_q;
   assign mem_write_o  = mem_wr_q;
   assign mem_addr_o   = mem_addr_q;
   assign mem_data_o   = mem_data_q;

   // Victim and new line share the CPU index, so one index serves every
   // access, including the writeback line read.
   dcache_sram #(
      .LINES     (LINES),
      .LINE_BITS (LINE_BITS)
   ) u_sram (
      .clk_i      (clk_i),
      .we_i       (sram_we),
      .full_i     (sram_full),
      .idx_i      (idx),
      .word_sel_i (wsel),
      .line_i     (mem_data_i),
      .word_i     (cpu_data_i),
      .line_o     (line_rd)
   );

   always_comb begin
      state_d    = state_q;
      valid_d    = valid_q;
      dirty_d    = dirty_q;
      mem_en_d   = mem_en_q;
      mem_wr_d   = mem_wr_q;
      mem_addr_d = mem_addr_q;
      mem_data_d = mem_data_q;
      tag_we     = 1'b0;
      sram_we    = 1'b0;
      sram_full  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (hit && cpu_write_i) begin
               sram_we      = 1'b1;
               dirty_d[idx] = 1'b1;
            end else if (cpu_req_i && !hit) begin
               mem_en_d = 1'b1;
               if (valid_q[idx] && dirty_q[idx]) begin
                  state_d    = ST_WRITEBACK;
                  mem_wr_d   = 1'b1;
                  mem_addr_d = {tag_q[idx], idx, {OFFSET_W{1'b0}}};
                  mem_data_d = line_rd;
               end else begin
                  state_d    = ST_ALLOCATE;
                  mem_wr_d   = 1'b0;
                  mem_addr_d = {cpu_addr_i[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
               end
            end
         end
         ST_WRITEBACK: begin
            if (mem_ack_i) begin
               state_d    = ST_ALLOCATE;
               mem_wr_d   = 1'b0;
               mem_addr_d = {cpu_addr_i[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
            end
         end
         ST_ALLOCATE: begin
            if (mem_ack_i) begin
               state_d      = ST_REFILL;
               mem_en_d     = 1'b0;
               sram_we      = 1'b1;
               sram_full    = 1'b1;
               tag_we       = 1'b1;
               valid_d[idx] = 1'b1;
               dirty_d[idx] = 1'b0;
            end
         end
         ST_REFILL: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!start_i) begin
         state_q    <= ST_IDLE;
         valid_q    <= '0;
         dirty_q    <= '0;
         mem_en_q   <= 1'b0;
         mem_wr_q   <= 1'b0;
         mem_addr_q <= '0;
         mem_data_q <= '0;
      end else begin
         state_q    <= state_d;
         valid_q    <= valid_d;
         dirty_q    <= dirty_d;
         mem_en_q   <= mem_en_d;
         mem_wr_q   <= mem_wr_d;
         mem_addr_q <= mem_addr_d;
         mem_data_q <= mem_data_d;
      end
   end

   // Tags need no reset; valid_q qualifies them.
   always_ff @(posedge clk_i) begin
      if (start_i && tag_we) begin
         tag_q[idx] <= addr_tag;
      end
   end

endmodule

// File: tb/tb_dcache_controller.sv
module tb_dcache_controller;

   logic         clk_i = 1'b0;
   logic         start_i;
   logic         cpu_req_i;
   logic         cpu_write_i;
   logic [31:0]  cpu_addr_i;
   logic [31:0]  cpu_data_i;
   logic [31:0]  cpu_data_o;
   logic         cpu_stall_o;
   logic         mem_enable_o;
   logic         mem_write_o;
   logic [31:0]  mem_addr_o;
   logic [255:0] mem_data_o;
   logic [255:0] mem_data_i;
   logic         mem_ack_i;

   always #5 clk_i = ~clk_i;

   dcache_controller dut (
      .clk_i        (clk_i),
      .start_i      (start_i),
      .cpu_req_i    (cpu_req_i),
      .cpu_write_i  (cpu_write_i),
      .cpu_addr_i   (cpu_addr_i),
      .cpu_data_i   (cpu_data_i),
      .cpu_data_o   (cpu_data_o),
      .cpu_stall_o  (cpu_stall_o),
      .mem_enable_o (mem_enable_o),
      .mem_write_o  (mem_write_o),
      .mem_addr_o   (mem_addr_o),
      .mem_data_o   (mem_data_o),
      .mem_data_i   (mem_data_i),
      .mem_ack_i    (mem_ack_i)
   );

   int tests = 0;
   int fails = 0;

   // memory responder: ack on the Nth enabled cycle, one idle turnaround
   // cycle after every ack before counting the next request
   int          lat_n = 3;
   int          mcnt = 0;
   bit          mskip = 0;
   int          n_reads = 0;
   int          n_writes = 0;
   logic [31:0] last_wb_addr, last_wb_w1, last_rd_addr;
   logic [31:0] exp_wb_addr, exp_rd_addr;

   // reference model: cache directory plus the CPU-visible word values
   logic [22:0] m_tag   [16];
   bit          m_valid [16];
   bit          m_dirty [16];
   logic [31:0] golden  [logic [31:0]];
   logic [31:0] backing [logic [31:0]];

   function automatic logic [31:0] dflt(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC0FF_EE00;
   endfunction

   function automatic logic [31:0] bk(input logic [31:0] a);
      return backing.exists(a) ? backing[a] : dflt(a);
   endfunction

   function automatic logic [31:0] gold(input logic [31:0] a);
      return golden.exists(a) ? golden[a] : bk(a);
   endfunction

   task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         m_valid[i] = 0;
         m_dirty[i] = 0;
      end
      golden.delete();
      mcnt  = 0;
      mskip = 0;
   endtask

   task automatic mem_step();
      logic [31:0] a;
      mem_ack_i = 1'b0;
      if (mem_enable_o) begin
         if (mskip) begin
            mskip = 0;
         end else begin
            mcnt++;
            if (mcnt >= lat_n) begin
               mem_ack_i = 1'b1;
               mcnt  = 0;
               mskip = 1;
               a = mem_addr_o;
               if (mem_write_o) begin
                  n_writes++;
                  last_wb_addr = a;
                  last_wb_w1   = mem_data_o[63:32];
                  check32("wb_addr", a, exp_wb_addr);
                  for (int w = 0; w < 8; w++) begin
                     check32("wb_data", mem_data_o[w*32 +: 32], gold(a + 32'(4*w)));
                     backing[a + 32'(4*w)] = mem_data_o[w*32 +: 32];
                  end
               end else begin
                  n_reads++;
                  last_rd_addr = a;
                  check32("rd_addr", a, exp_rd_addr);
                  for (int w = 0; w < 8; w++)
                     mem_data_i[w*32 +: 32] = bk(a + 32'(4*w));
               end
            end
         end
      end else begin
         mcnt  = 0;
         mskip = 0;
      end
   endtask

   task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         output int stalls);
      int   idx, exp_stall, r0, w0;
      bit   hit, dmiss, done;
      idx   = int'(addr[8:5]);
      hit   = m_valid[idx] && (m_tag[idx] == addr[31:9]);
      dmiss = !hit && m_valid[idx] && m_dirty[idx];
      exp_rd_addr = {addr[31:5], 5'b0};
      exp_wb_addr = {m_tag[idx], addr[8:5], 5'b0};
      exp_stall = hit ? 0 : (dmiss ? 2*lat_n + 3 : lat_n + 2);
      r0 = n_reads;
      w0 = n_writes;
      @(negedge clk_i);
      cpu_req_i   = 1'b1;
      cpu_write_i = wr;
      cpu_addr_i  = addr;
      cpu_data_i  = data;
      stalls = 0;
      done   = 0;
      for (int c = 0; c < 400; c++) begin
         mem_step();
         #1;
         if (!cpu_stall_o) begin
            done = 1;
            break;
         end
         stalls++;
         @(negedge clk_i);
      end
      if (!done) begin
         tests++;
         fails++;
         $display("FAIL stall_timeout: addr %h still stalled after 400 cycles", addr);
      end
      check32("stall_len", 32'(stalls), 32'(exp_stall));
      check32("mem_reads", 32'(n_reads - r0), hit ? 32'd0 : 32'd1);
      check32("mem_writes", 32'(n_writes - w0), dmiss ? 32'd1 : 32'd0);
      if (!wr) check32("load_data", cpu_data_o, gold(addr));
      if (!hit) begin
         m_valid[idx] = 1;
         m_tag[idx]   = addr[31:9];
         m_dirty[idx] = 0;
      end
      if (wr) begin
         m_dirty[idx]  = 1;
         golden[addr]  = data;
      end
   endtask

   initial begin
      int  s;
      bit  seen_wb;
      logic [31:0] a;
      start_i     = 1'b0;
      cpu_req_i   = 1'b0;
      cpu_write_i = 1'b0;
      cpu_addr_i  = '0;
      cpu_data_i  = '0;
      mem_data_i  = '0;
      mem_ack_i   = 1'b0;
      model_reset();
      repeat (2) @(negedge clk_i);
      start_i = 1'b1;
      #1;
      check32("rst_stall", 32'(cpu_stall_o), 0);
      check32("rst_mem_en", 32'(mem_enable_o), 0);
      check32("rst_mem_wr", 32'(mem_write_o), 0);
      check32("rst_mem_addr", mem_addr_o, 0);
      check32("rst_mem_data", 32'(|mem_data_o), 0);
      check32("rst_cpu_data", cpu_data_o, 0);

      // directed: cold load, hit, store, dirty conflict, clean conflict
      lat_n = 3;
      access(0, 32'h0000_0104, 0, s);
      check32("cold_stall", 32'(s), 5);
      check32("cold_rd_addr", last_rd_addr, 32'h0000_0100);
      access(0, 32'h0000_0108, 0, s);
      check32("hit_stall", 32'(s), 0);
      access(1, 32'h0000_0104, 32'hDEAD_BEEF, s);
      check32("store_hit_stall", 32'(s), 0);
      access(0, 32'h0000_0304, 0, s);
      check32("dirty_stall", 32'(s), 9);
      check32("dirty_wb_addr", last_wb_addr, 32'h0000_0100);
      check32("dirty_wb_word1", last_wb_w1, 32'hDEAD_BEEF);
      check32("dirty_rd_addr", last_rd_addr, 32'h0000_0300);
      access(0, 32'h0000_0304, 0, s);
      check32("replay_hit_stall", 32'(s), 0);
      access(0, 32'h0000_0104, 0, s);
      check32("clean_stall", 32'(s), 5);

      // reset in the middle of a writeback, with ack during and after reset
      access(1, 32'h0000_0104, 32'h1234_5678, s);
      lat_n = 10;
      @(negedge clk_i);
      cpu_req_i   = 1'b1;
      cpu_write_i = 1'b0;
      cpu_addr_i  = 32'h0000_0304;
      mem_ack_i   = 1'b0;
      seen_wb = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk_i);
         if (mem_enable_o && mem_write_o) begin
            seen_wb = 1;
            break;
         end
      end
      check32("wb_entered", 32'(seen_wb), 1);
      start_i   = 1'b0;
      cpu_req_i = 1'b0;
      @(negedge clk_i);
      mem_ack_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b1;
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      #1;
      check32("midrst_mem_en", 32'(mem_enable_o), 0);
      check32("midrst_stall", 32'(cpu_stall_o), 0);
      check32("midrst_cpu_data", cpu_data_o, 0);
      model_reset();
      lat_n = 3;
      access(0, 32'h0000_0104, 0, s);
      check32("reload_stall", 32'(s), 5);

      // idle with stray acks
      @(negedge clk_i);
      cpu_req_i = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk_i);
         mem_ack_i = 1'(($urandom_range(0, 1)));
         #1;
         check32("idle_stall", 32'(cpu_stall_o), 0);
         check32("idle_mem_en", 32'(mem_enable_o), 0);
      end
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      access(0, 32'h0000_0104, 0, s);
      check32("post_idle_hit", 32'(s), 0);

      // randomized traffic over a few conflicting tags
      for (int k = 0; k < 120; k++) begin
         lat_n = $urandom_range(1, 5);
         a = {21'($urandom_range(0, 3)), 2'b00, 4'($urandom_range(0, 15)),
              3'($urandom_range(0, 7)), 2'b00};
         access(1'($urandom_range(0, 1)), a, $urandom, s);
         if ($urandom_range(0, 3) == 0) begin
            @(negedge clk_i);
            cpu_req_i = 1'b0;
            #1;
            check32("gap_stall", 32'(cpu_stall_o), 0);
         end
      end

      @(negedge clk_i);
      cpu_req_i = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
